countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of BCD digits, legal range 2..8.
REQ-002 SHALL have parameter TIME_MODE, default 1: 0 = plain decimal; 1 = MM:SS, with digit 1 (seconds tens) counting 0..5.
REQ-003 SHALL have parameter TICK_MOD, default 1000: CE ticks per count step; legal range 1..65535.
REQ-004 SHALL have parameter BLINK_MOD, default 250: CE ticks per BLINK toggle.
REQ-005 SHALL have port CLK, input, 1: sole clock; all state on rising edge.
REQ-006 SHALL have port CLR, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port CE, input, 1: 1 ms clock-enable tick, one CLK cycle wide.
REQ-008 SHALL have port START, input, 1: one-cycle pulse that toggles run/pause.
REQ-009 SHALL have port LOAD, input, 1: one-cycle pulse that loads LOAD_VAL and aborts any count.
REQ-010 SHALL have port LOAD_VAL, input, 4*DIGITS: BCD preset; digit 0 is at [3:0].
REQ-011 SHALL have port INC, input, 1: one-cycle pulse that adds one unit to the preset (debouncer KEY_UP).
REQ-012 SHALL have port Q, output, 4*DIGITS: current BCD value.
REQ-013 SHALL have port RUNNING, output, 1: high in state RUN.
REQ-014 SHALL have port DONE, output, 1: one-cycle pulse on expiry.
REQ-015 SHALL have port ALARM, output, 1: high in state EXPIRED.
REQ-016 SHALL have port BLINK, output, 1: square wave while EXPIRED; 0 otherwise.

Function
REQ-017 SHALL implement the states IDLE, RUN, PAUSE and EXPIRED.
REQ-018 SHALL make the transition IDLE->RUN on START when Q != 0; START SHALL be ignored when Q == 0.
REQ-019 SHALL make the transition RUN->PAUSE on START, and PAUSE->RUN on START.
REQ-020 SHALL make the transition RUN->EXPIRED in the cycle after Q reaches all-zero, pulsing DONE for exactly one cycle.
REQ-021 SHALL make the transition EXPIRED->IDLE on START or LOAD; Q SHALL remain 0 on that transition.
REQ-022 SHALL act on LOAD in any state: go to IDLE and set Q = LOAD_VAL in the next cycle; LOAD SHALL have priority over START and INC when they coincide.
REQ-023 SHALL clamp each LOAD_VAL digit above its maximum (9, or 5 for the seconds-tens digit in MM:SS mode) to that maximum.
REQ-024 SHALL increment Q by one on INC only in IDLE, with BCD carry (MM:SS mode: 00:59 -> 01:00); wrap from the all-max value to 0; ignore INC in other states.
REQ-025 SHALL run the prescaler only in RUN; it SHALL count CE ticks and request one decrement when it reaches TICK_MOD.
REQ-026 SHALL clear the prescaler on IDLE->RUN and hold it in PAUSE, so that resume continues the partial step.
REQ-027 SHALL update Q on the CLK cycle after the CE that completes the step (latency 1).
REQ-028 SHALL decrement with a borrow cascade across all digits in a single cycle; no division or binary-to-BCD conversion is permitted.
REQ-029 SHALL never let Q underflow below 0.
REQ-030 SHALL toggle BLINK every BLINK_MOD CE ticks, starting high on entry to EXPIRED.
REQ-031 SHALL drive RUNNING, ALARM and BLINK as registered outputs.

Reset
REQ-032 SHALL, while CLR = 0, set state = IDLE, Q = 0, prescaler = 0, blink counter = 0, and DONE, RUNNING, ALARM and BLINK = 0.
REQ-033 SHALL abort any count in progress when reset is asserted mid-RUN, without emitting DONE.

Structure
REQ-034 SHALL place the state encoding, TIME_MODE constants and per-digit maxima in the shared package countdown_pkg.
REQ-035 SHALL use one sub-module, bcd_digit, per digit: a loadable BCD digit with parameter MAX, inc/dec enable, and carry/borrow out; digits SHALL be instanced by generate.

Verification
REQ-036 SHALL test decrement with TICK_MOD=2, TIME_MODE=1: LOAD 01:00, START, 4 CE -> Q = 00:58; 120 CE in total -> Q = 00:00, DONE pulses once, ALARM = 1.
REQ-037 SHALL test pause: RUN from 00:10, START after 3 CE (prescaler mid-step), 50 idle CE, then START and 1 CE -> Q = 00:08.
REQ-038 SHALL test LOAD/INC priority: LOAD 00:05 and START in the same cycle -> state IDLE, Q = 00:05; then 55 INC -> Q = 01:00.
REQ-039 SHALL test clamping and wrap: TIME_MODE=0, LOAD 16'hFA9C -> Q = 9999; one INC -> Q = 0000; START -> ignored, RUNNING = 0.
REQ-040 SHALL test reset mid-RUN: CLR low asynchronously mid-RUN -> all outputs 0 immediately, no DONE afterwards.
REQ-041 SHALL test BLINK: BLINK_MOD=3 in EXPIRED -> BLINK toggles every 3 CE; START -> BLINK = 0 and ALARM = 0.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared constants for the countdown timer: FSM encoding, display modes and
// the per-digit maximum used for clamping, carry and borrow.
package countdown_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSE   = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    localparam int MODE_DEC  = 0;
    localparam int MODE_MMSS = 1;

    localparam logic [3:0] DEC_DIGIT_MAX = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX  = 4'd5;

    // Digit 1 is the seconds-tens position when the display is MM:SS.
    function automatic logic [3:0] digit_max(input int mode, input int idx);
        if (mode != MODE_DEC && idx == 1) return SEC_TENS_MAX;
        return DEC_DIGIT_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One loadable BCD digit with modulus MAX+1; carry/borrow out are combinational
// so a whole row of digits steps in a single cycle.
module bcd_digit
    import countdown_pkg::*;
#(
    parameter logic [3:0] MAX = DEC_DIGIT_MAX
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] q,
    output logic       carry,
    output logic       borrow
);

    assign carry  = inc && (q == MAX);
    assign borrow = dec && (q == 4'd0);

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR)
            q <= 4'd0;
        else if (load)
            q <= (load_val > MAX) ? MAX : load_val;
        else if (inc)
            q <= carry ? 4'd0 : q + 4'd1;
        else if (dec)
            q <= borrow ? MAX : q - 4'd1;
    end

endmodule

// File: rtl/countdown_timer.sv
// BCD countdown timer with run/pause control, CE-driven prescaler, one-shot
// DONE on expiry and a blinking alarm indication while expired.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int TIME_MODE = MODE_MMSS,
    parameter int TICK_MOD  = 1000,
    parameter int BLINK_MOD = 250
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  CE,
    input  logic                  START,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   LOAD_VAL,
    input  logic                  INC,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  RUNNING,
    output logic                  DONE,
    output logic                  ALARM,
    output logic                  BLINK
);

    logic [1:0]              state, state_nxt;
    logic [15:0]             presc;
    logic [15:0]             blink_cnt;
    logic [DIGITS-1:0][3:0]  q_d;
    logic [DIGITS:0]         inc_chain, dec_chain;
    logic                    q_zero, run_tick, presc_wrap, inc_en, dec_en;
    logic                    unused_chain_out;

    assign Q          = q_d;
    assign q_zero     = (q_d == '0);
    // A START in RUN pauses without consuming the coincident CE.
    assign run_tick   = (state == ST_RUN) && !LOAD && !START && !q_zero && CE;
    assign presc_wrap = (presc == 16'(TICK_MOD - 1));
    assign dec_en     = run_tick && presc_wrap;
    assign inc_en     = (state == ST_IDLE) && INC && !LOAD;

    assign inc_chain[0] = inc_en;
    assign dec_chain[0] = dec_en;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit #(.MAX(digit_max(TIME_MODE, i))) u_digit (
            .CLK      (CLK),
            .CLR      (CLR),
            .load     (LOAD),
            .load_val (LOAD_VAL[4*i +: 4]),
            .inc      (inc_chain[i]),
            .dec      (dec_chain[i]),
            .q        (q_d[i]),
            .carry    (inc_chain[i+1]),
            .borrow   (dec_chain[i+1])
        );
    end

    // Top carry is the all-max wrap (handled by each digit); top borrow cannot
    // occur because decrement is gated on a non-zero value.
    assign unused_chain_out = inc_chain[DIGITS] ^ dec_chain[DIGITS];

    always_comb begin
        state_nxt = state;
        if (LOAD) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (START && !q_zero) state_nxt = ST_RUN;
                ST_RUN:     if (q_zero)           state_nxt = ST_EXPIRED;
                            else if (START)       state_nxt = ST_PAUSE;
                ST_PAUSE:   if (START)            state_nxt = ST_RUN;
                ST_EXPIRED: if (START)            state_nxt = ST_IDLE;
                default:                          state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state     <= ST_IDLE;
            presc     <= '0;
            blink_cnt <= '0;
            DONE      <= 1'b0;
            RUNNING   <= 1'b0;
            ALARM     <= 1'b0;
            BLINK     <= 1'b0;
        end else begin
            state   <= state_nxt;
            DONE    <= (state == ST_RUN) && (state_nxt == ST_EXPIRED);
            RUNNING <= (state_nxt == ST_RUN);
            ALARM   <= (state_nxt == ST_EXPIRED);

            // PAUSE holds the prescaler so a resume finishes the partial step.
            if (state == ST_IDLE && state_nxt == ST_RUN)
                presc <= '0;
            else if (run_tick)
                presc <= presc_wrap ? 16'd0 : presc + 16'd1;

            if (state_nxt != ST_EXPIRED) begin
                BLINK     <= 1'b0;
                blink_cnt <= '0;
            end else if (state != ST_EXPIRED) begin
                BLINK     <= 1'b1;
                blink_cnt <= '0;
            end else if (CE) begin
                if (blink_cnt == 16'(BLINK_MOD - 1)) begin
                    blink_cnt <= '0;
                    BLINK     <= ~BLINK;
                end else begin
                    blink_cnt <= blink_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench: two timer instances (MM:SS and plain decimal) share one
// stimulus stream; a value-level model predicts every cycle's outputs.
module tb_countdown_timer;

    localparam int ST_I = 0, ST_R = 1, ST_P = 2, ST_E = 3;

    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic        CE = 1'b0, START = 1'b0, LOAD = 1'b0, INC = 1'b0;
    logic [15:0] LOAD_VAL = 16'h0;
    logic [15:0] q_a, q_b;
    logic        run_a, done_a, alarm_a, blink_a;
    logic        run_b, done_b, alarm_b, blink_b;

    countdown_timer #(.DIGITS(4), .TIME_MODE(1), .TICK_MOD(2), .BLINK_MOD(3)) dut_a (
        .CLK(CLK), .CLR(CLR), .CE(CE), .START(START), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
        .INC(INC), .Q(q_a), .RUNNING(run_a), .DONE(done_a), .ALARM(alarm_a), .BLINK(blink_a));

    countdown_timer #(.DIGITS(4), .TIME_MODE(0), .TICK_MOD(3), .BLINK_MOD(4)) dut_b (
        .CLK(CLK), .CLR(CLR), .CE(CE), .START(START), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
        .INC(INC), .Q(q_b), .RUNNING(run_b), .DONE(done_b), .ALARM(alarm_b), .BLINK(blink_b));

    always #5 CLK = ~CLK;

    typedef struct { int st; int val; int presc; int blink; int bcnt; int done; } mdl_t;

    mdl_t        m[2];
    logic [19:0] sbq_a[$];
    logic [19:0] sbq_b[$];
    int          total = 0, bad = 0, n_done_a = 0;
    bit          hold_rst = 1'b1;

    function automatic int mode_of(int k); return (k == 0) ? 1 : 0; endfunction
    function automatic int tick_of(int k); return (k == 0) ? 2 : 3; endfunction
    function automatic int bmod_of(int k); return (k == 0) ? 3 : 4; endfunction
    function automatic int maxv_of(int k); return (k == 0) ? 5999 : 9999; endfunction

    // Preset as a plain count of units (seconds in MM:SS, ones in decimal).
    function automatic int units_of(logic [15:0] lv, int mode);
        int d[4];
        for (int i = 0; i < 4; i++) begin
            d[i] = int'(lv[4*i +: 4]);
            if (d[i] > 9) d[i] = 9;
        end
        if (mode == 1) begin
            if (d[1] > 5) d[1] = 5;
            return (d[3]*10 + d[2])*60 + d[1]*10 + d[0];
        end
        return d[3]*1000 + d[2]*100 + d[1]*10 + d[0];
    endfunction

    function automatic logic [15:0] bcd_of(int v, int mode);
        int mm, ss;
        if (mode == 1) begin
            mm = v / 60; ss = v % 60;
            return {4'(mm/10), 4'(mm%10), 4'(ss/10), 4'(ss%10)};
        end
        return {4'(v/1000), 4'((v/100)%10), 4'((v/10)%10), 4'(v%10)};
    endfunction

    function automatic mdl_t mstep(mdl_t s, int k, bit clr, bit ce, bit st, bit ld,
                                   logic [15:0] lv, bit inc);
        mdl_t n;
        n = s;
        n.done = 0;
        if (!clr) begin
            n = '{default: 0};
            return n;
        end
        if (ld) begin
            n.st  = ST_I;
            n.val = units_of(lv, mode_of(k));
        end else begin
            case (s.st)
                ST_I: if (inc) n.val = (s.val + 1) % (maxv_of(k) + 1);
                      else if (st && s.val != 0) begin n.st = ST_R; n.presc = 0; end
                ST_R: if (s.val == 0) begin
                          n.st = ST_E; n.done = 1; n.blink = 1; n.bcnt = 0;
                      end else if (st) begin
                          n.st = ST_P;
                      end else if (ce) begin
                          n.presc = s.presc + 1;
                          if (n.presc == tick_of(k)) begin n.presc = 0; n.val = s.val - 1; end
                      end
                ST_P: if (st) n.st = ST_R;
                default: if (st) n.st = ST_I;
                      else if (ce) begin
                          n.bcnt = s.bcnt + 1;
                          if (n.bcnt == bmod_of(k)) begin n.bcnt = 0; n.blink = 1 - s.blink; end
                      end
            endcase
        end
        if (n.st != ST_E) begin n.blink = 0; n.bcnt = 0; end
        return n;
    endfunction

    function automatic logic [19:0] exp_of(mdl_t s, int k);
        logic r, d, a, b;
        r = (s.st == ST_R); d = (s.done != 0); a = (s.st == ST_E); b = (s.blink != 0);
        return {bcd_of(s.val, mode_of(k)), r, d, a, b};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: one expectation per clock edge, compared just after the edge.
    always @(posedge CLK) begin
        #1;
        if (done_a) n_done_a++;
        if (sbq_a.size() > 0) chk("sb_a q_rdab", {q_a, run_a, done_a, alarm_a, blink_a}, sbq_a.pop_front());
        if (sbq_b.size() > 0) chk("sb_b q_rdab", {q_b, run_b, done_b, alarm_b, blink_b}, sbq_b.pop_front());
    end

    task automatic step(input bit ce, input bit st, input bit ld, input logic [15:0] lv, input bit inc);
        @(negedge CLK);
        CLR = !hold_rst; CE = ce; START = st; LOAD = ld; LOAD_VAL = lv; INC = inc;
        for (int k = 0; k < 2; k++) m[k] = mstep(m[k], k, !hold_rst, ce, st, ld, lv, inc);
        sbq_a.push_back(exp_of(m[0], 0));
        sbq_b.push_back(exp_of(m[1], 1));
    endtask

    task automatic idle();                  step(0, 0, 0, 16'h0, 0); endtask
    task automatic tick(input int n);       for (int i = 0; i < n; i++) step(1, 0, 0, 16'h0, 0); endtask
    task automatic start();                 step(0, 1, 0, 16'h0, 0); endtask
    task automatic load(input logic [15:0] v); step(0, 0, 1, v, 0); endtask
    task automatic settle();                @(posedge CLK); #1; endtask

    // Must follow settle(): drops CLR between edges, then checks it bites at once.
    task automatic async_reset();
        #1;
        CLR = 1'b0;
        hold_rst = 1'b1;
        #1;
        chk("async_rst_a", {q_a, run_a, done_a, alarm_a, blink_a}, 20'h0);
        chk("async_rst_b", {q_b, run_b, done_b, alarm_b, blink_b}, 20'h0);
    endtask

    initial begin
        int snap;
        m[0] = '{default: 0};
        m[1] = '{default: 0};

        // Reset state
        hold_rst = 1'b1;
        idle(); idle();
        settle();
        chk("reset_q_a", q_a, 16'h0);
        hold_rst = 1'b0;
        idle();

        // Decrement to expiry, then blink
        snap = n_done_a;
        load(16'h0100); start(); tick(4);
        settle(); chk("dec4_q", q_a, 16'h0058);
        tick(116);
        settle(); chk("dec120_q", q_a, 16'h0000);
        idle();
        settle(); chk("expire_alarm", alarm_a, 1'b1); chk("expire_blink", blink_a, 1'b1);
        tick(2);
        settle(); chk("blink_hold", blink_a, 1'b1);
        tick(1);
        settle(); chk("blink_tog1", blink_a, 1'b0);
        tick(3);
        settle(); chk("blink_tog2", blink_a, 1'b1);
        chk("done_once", n_done_a - snap, 1);
        start();
        settle(); chk("exp_exit_blink", blink_a, 1'b0); chk("exp_exit_alarm", alarm_a, 1'b0);
        chk("exp_exit_q", q_a, 16'h0);

        // Pause keeps the partial prescaler step
        load(16'h0010); start(); tick(3);
        settle(); chk("pause_pre_q", q_a, 16'h0009);
        start(); tick(50);
        settle(); chk("pause_hold_q", q_a, 16'h0009); chk("pause_run", run_a, 1'b0);
        start(); tick(1);
        settle(); chk("resume_q", q_a, 16'h0008);

        // LOAD wins over START; INC with MM:SS carry
        step(0, 1, 1, 16'h0005, 0);
        settle(); chk("ld_prio_q", q_a, 16'h0005); chk("ld_prio_run", run_a, 1'b0);
        for (int i = 0; i < 55; i++) step(0, 0, 0, 16'h0, 1);
        settle(); chk("inc55_q", q_a, 16'h0100); chk("inc55_q_dec", q_b, 16'h0060);

        // Clamp and wrap
        load(16'hFA9C);
        settle(); chk("clamp_dec", q_b, 16'h9999); chk("clamp_mmss", q_a, 16'h9959);
        step(0, 0, 0, 16'h0, 1);
        settle(); chk("wrap_dec", q_b, 16'h0000); chk("wrap_mmss", q_a, 16'h0000);
        start();
        settle(); chk("zero_start_b", run_b, 1'b0); chk("zero_start_a", run_a, 1'b0);

        // Reset mid-RUN
        load(16'h0003); start(); tick(2);
        settle(); chk("prerst_run", run_a, 1'b1); chk("prerst_q", q_a, 16'h0002);
        snap = n_done_a;
        async_reset();
        idle(); idle();
        hold_rst = 1'b0;
        tick(10);
        settle(); chk("no_done_after_rst", n_done_a - snap, 0);

        // Randomized traffic
        for (int c = 0; c < 2500; c++) begin
            bit          ce, st, ld, inc;
            logic [15:0] lv;
            int          r;
            ce  = ($urandom_range(0, 1) == 1);
            r   = $urandom_range(0, 99);
            st  = (r < 5);
            inc = (r >= 5 && r < 20);
            ld  = (r >= 20 && r < 23);
            lv  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {12'h000, 4'($urandom_range(0, 6))};
            if ($urandom_range(0, 499) == 0) begin
                settle(); async_reset(); idle(); hold_rst = 1'b0;
            end
            step(ce, st, ld, lv, inc);
        end
        idle();
        settle();
        @(negedge CLK);
        chk("sb_drain", sbq_a.size() + sbq_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
